cpu_controller: RTL and testbench

Instruction register, decoder and control FSM that sits directly upstream of the register-file/ALU datapath. Accepts one 16-bit instruction per valid/ready handshake, sequences it over several cycles, and produces every datapath control input. Also supplies the immediate and register-select fields. Signals completion with a one-cycle done pulse.

---
 rtl/cpu_pkg.sv | 80 ++++++++
 rtl/instr_decoder.sv | 32 +++
 rtl/cpu_controller.sv | 139 +++++++++++++
 tb/tb_cpu_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: encodings, FSM state type and IR field helpers shared by the
// controller, its decoder and the register-file/ALU datapath.
package cpu_pkg;

   // Opcode field values
   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   // Op field values within each opcode
   localparam logic [1:0] OP_MOVI = 2'b10;
   localparam logic [1:0] OP_MOVR = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_CMP  = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_MVN  = 2'b11;

   // Writeback mux selects
   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_PC    = 2'b01;
   localparam logic [1:0] VSEL_IMM   = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

   // ALU operations
   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;
   localparam logic [1:0] ALUOP_AND = 2'b10;
   localparam logic [1:0] ALUOP_NOT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_WR_IMM, S_LD_A, S_LD_B, S_EXEC, S_CMP, S_WR_C
   } state_t;

   typedef enum logic [2:0] {
      CLS_MOVI, CLS_MOVR, CLS_ADD, CLS_CMP, CLS_AND, CLS_MVN, CLS_ILL
   } instr_class_t;

   typedef struct packed {
      instr_class_t cls;
      logic [2:0]   rn;
      logic [2:0]   rd;
      logic [2:0]   rm;
      logic [1:0]   sh;
      logic [4:0]   imm5;
      logic [15:0]  sximm8;
      logic         legal;
   } decode_t;

   function automatic logic [2:0] f_opcode(input logic [15:0] ir);
      return ir[15:13];
   endfunction

   function automatic logic [1:0] f_op(input logic [15:0] ir);
      return ir[12:11];
   endfunction

   function automatic logic [2:0] f_rn(input logic [15:0] ir);
      return ir[10:8];
   endfunction

   function automatic logic [2:0] f_rd(input logic [15:0] ir);
      return ir[7:5];
   endfunction

   function automatic logic [1:0] f_sh(input logic [15:0] ir);
      return ir[4:3];
   endfunction

   function automatic logic [2:0] f_rm(input logic [15:0] ir);
      return ir[2:0];
   endfunction

   function automatic logic [4:0] f_imm5(input logic [15:0] ir);
      return ir[4:0];
   endfunction

   function automatic logic [15:0] f_sximm8(input logic [15:0] ir);
      return {{8{ir[7]}}, ir[7:0]};
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational split of the IR into instruction class
// and operand fields.
module instr_decoder
   import cpu_pkg::*;
(
   input  logic [15:0] ir,
   output decode_t     dec
);

   // Classify opcode/op and slice the operand fields out of the IR.
   always_comb begin
      // NOTE: every output gets a value before the case, so no path can infer a latch.
      dec.cls    = CLS_ILL;
      dec.rn     = f_rn(ir);
      dec.rd     = f_rd(ir);
      dec.rm     = f_rm(ir);
      dec.sh     = f_sh(ir);
      dec.imm5   = f_imm5(ir);
      dec.sximm8 = f_sximm8(ir);
      case ({f_opcode(ir), f_op(ir)})
         {OPC_MOV, OP_MOVI}: dec.cls = CLS_MOVI;
         {OPC_MOV, OP_MOVR}: dec.cls = CLS_MOVR;
         {OPC_ALU, OP_ADD}:  dec.cls = CLS_ADD;
         {OPC_ALU, OP_CMP}:  dec.cls = CLS_CMP;
         {OPC_ALU, OP_AND}:  dec.cls = CLS_AND;
         {OPC_ALU, OP_MVN}:  dec.cls = CLS_MVN;
         default:            dec.cls = CLS_ILL;
      endcase
      dec.legal = (dec.cls != CLS_ILL);
   end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: instruction register plus Moore control FSM driving the
// register-file/ALU datapath, one instruction per valid/ready handshake.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int IW = 16,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   input  logic [IW-1:0] instr,
   output logic          instr_ready,
   output logic          done,
   output logic          illegal,
   output logic [RW-1:0] readnum,
   output logic [RW-1:0] writenum,
   output logic          write,
   output logic [1:0]    vsel,
   output logic          loada,
   output logic          loadb,
   output logic          loadc,
   output logic          loads,
   output logic          asel,
   output logic          bsel,
   output logic [1:0]    ALUop,
   output logic [1:0]    shift,
   output logic [4:0]    imm5,
   output logic [15:0]   sximm8
);

   state_t        state, next_state;
   logic [IW-1:0] ir;
   decode_t       dec;
   logic          accept;

   assign instr_ready = (state == S_IDLE);
   assign accept      = instr_valid && instr_ready;

   instr_decoder u_dec (
      .ir  (ir),
      .dec (dec)
   );

   // Instruction register: loads only on an accepted handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir <= '0;
      end else if (accept) begin
         // NOTE: non-blocking assignment so every flop samples pre-edge values.
         ir <= instr;
      end
   end

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // Next-state sequencing per instruction class.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (accept) next_state = S_DECODE;
         S_DECODE: begin
            case (dec.cls)
               CLS_MOVI:                  next_state = S_WR_IMM;
               CLS_ADD, CLS_AND, CLS_CMP: next_state = S_LD_A;
               CLS_MOVR, CLS_MVN:         next_state = S_LD_B;
               default:                   next_state = S_IDLE;
            endcase
         end
         S_WR_IMM: next_state = S_IDLE;
         S_LD_A:   next_state = S_LD_B;
         S_LD_B:   next_state = (dec.cls == CLS_CMP) ? S_CMP : S_EXEC;
         S_EXEC:   next_state = S_WR_C;
         S_CMP:    next_state = S_IDLE;
         S_WR_C:   next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Datapath controls decoded from state and IR only.
   always_comb begin
      done     = 1'b0;
      illegal  = 1'b0;
      readnum  = '0;
      writenum = '0;
      write    = 1'b0;
      vsel     = VSEL_C;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      ALUop    = ALUOP_ADD;
      case (state)
         S_DECODE: illegal = !dec.legal;
         S_WR_IMM: begin
            writenum = dec.rn;
            vsel     = VSEL_IMM;
            write    = 1'b1;
            done     = 1'b1;
         end
         S_LD_A: begin
            readnum = dec.rn;
            loada   = 1'b1;
         end
         S_LD_B: begin
            readnum = dec.rm;
            loadb   = 1'b1;
         end
         S_EXEC: begin
            loadc = 1'b1;
            asel  = (dec.cls == CLS_MOVR);
            ALUop = (dec.cls == CLS_MOVR) ? ALUOP_ADD : f_op(ir);
         end
         S_CMP: begin
            ALUop = ALUOP_SUB;
            loads = 1'b1;
            done  = 1'b1;
         end
         S_WR_C: begin
            writenum = dec.rd;
            vsel     = VSEL_C;
            write    = 1'b1;
            done     = 1'b1;
         end
         default: ;
      endcase
   end

   assign shift  = dec.sh;
   assign imm5   = dec.imm5;
   assign sximm8 = dec.sximm8;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: table-driven vectors with a per-cycle expectation queue,
// plus hand sequences for held-valid back-to-back and reset mid-instruction.
module tb_cpu_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_ready, done, illegal, write;
   logic [2:0]  readnum, writenum;
   logic [1:0]  vsel, ALUop, shift;
   logic        loada, loadb, loadc, loads, asel, bsel;
   logic [4:0]  imm5;
   logic [15:0] sximm8;

   int errors = 0;
   int checks = 0;

   typedef enum int {K_MOVI, K_MOVR, K_ALU, K_CMP, K_MVN, K_ILL} kind_e;

   typedef struct packed {
      logic       ready;
      logic       done;
      logic       illegal;
      logic [2:0] readnum;
      logic [2:0] writenum;
      logic       write;
      logic [1:0] vsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic [1:0] aluop;
      logic [1:0] shift;
      logic [4:0] imm5;
      logic [15:0] sximm8;
   } obs_t;

   typedef struct {
      string       name;
      logic [15:0] instr;
      kind_e       kind;
      int          lat;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [2:0]  wr;
      logic [1:0]  aluop;
      logic [1:0]  sh;
      logic [4:0]  imm5;
      logic [15:0] sx;
   } vec_t;

   vec_t vecs[$];
   obs_t sb[$];
   obs_t act;

   assign act = {instr_ready, done, illegal, readnum, writenum, write, vsel,
                 loada, loadb, loadc, loads, asel, bsel, ALUop, shift, imm5, sximm8};

   cpu_controller dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .done        (done),
      .illegal     (illegal),
      .readnum     (readnum),
      .writenum    (writenum),
      .write       (write),
      .vsel        (vsel),
      .loada       (loada),
      .loadb       (loadb),
      .loadc       (loadc),
      .loads       (loads),
      .asel        (asel),
      .bsel        (bsel),
      .ALUop       (ALUop),
      .shift       (shift),
      .imm5        (imm5),
      .sximm8      (sximm8)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [47:0] actual, input logic [47:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Expected outputs k cycles after acceptance (k = lat+1 is back in IDLE).
   function automatic obs_t exp_at(input vec_t v, input int k);
      obs_t o;
      int   step;
      o        = '0;
      o.shift  = v.sh;
      o.imm5   = v.imm5;
      o.sximm8 = v.sx;
      if (k > v.lat) begin
         o.ready = 1'b1;
         return o;
      end
      if (k == 1) begin
         o.illegal = (v.kind == K_ILL);
         return o;
      end
      if (v.kind == K_MOVI) begin
         o.writenum = v.wr; o.vsel = 2'b10; o.write = 1'b1; o.done = 1'b1;
         return o;
      end
      step = (v.kind == K_MOVR || v.kind == K_MVN) ? k + 1 : k;
      case (step)
         2: begin o.readnum = v.ra; o.loada = 1'b1; end
         3: begin o.readnum = v.rb; o.loadb = 1'b1; end
         4: begin
            if (v.kind == K_CMP) begin
               o.aluop = 2'b01; o.loads = 1'b1; o.done = 1'b1;
            end else begin
               o.loadc = 1'b1; o.aluop = v.aluop; o.asel = (v.kind == K_MOVR);
            end
         end
         5: begin o.writenum = v.wr; o.write = 1'b1; o.done = 1'b1; end
         default: ;
      endcase
      return o;
   endfunction

   // Called at a negedge with the DUT idle; ends at the negedge of the IDLE cycle.
   task automatic run_vec(input vec_t v, input bit hold, input logic [15:0] nxt);
      obs_t e;
      check({v.name, "_ready"}, {47'b0, instr_ready}, 48'd1);
      instr_valid = 1'b1;
      instr       = v.instr;
      for (int k = 1; k <= v.lat + 1; k++) sb.push_back(exp_at(v, k));
      for (int k = 1; k <= v.lat + 1; k++) begin
         @(negedge clk);
         e = sb.pop_front();
         check($sformatf("%s_c%0d", v.name, k), {5'b0, act}, {5'b0, e});
         if (k == 1) begin
            if (hold) instr = nxt;
            else begin
               instr_valid = 1'b0;
               instr       = 16'hFFFF;
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t idle0;
      vec_t add_v;
      idle0       = '0;
      idle0.ready = 1'b1;

      //            name          instr     kind    lat ra    rb    wr    aluop  sh     imm5   sx
      vecs.push_back('{"movi_r0_7",  16'hD007, K_MOVI, 2, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 5'h07, 16'h0007});
      vecs.push_back('{"movr_r1_r0", 16'hC028, K_MOVR, 4, 3'd0, 3'd0, 3'd1, 2'b00, 2'b01, 5'h08, 16'h0028});
      vecs.push_back('{"add_r2",     16'hA140, K_ALU,  5, 3'd1, 3'd0, 3'd2, 2'b00, 2'b00, 5'h00, 16'h0040});
      vecs.push_back('{"mvn_r3",     16'hB860, K_MVN,  4, 3'd0, 3'd0, 3'd3, 2'b11, 2'b00, 5'h00, 16'h0060});
      vecs.push_back('{"cmp_r1_r0",  16'hA900, K_CMP,  4, 3'd1, 3'd0, 3'd0, 2'b01, 2'b00, 5'h00, 16'h0000});
      vecs.push_back('{"movr_r7_r6", 16'hC0FE, K_MOVR, 4, 3'd0, 3'd6, 3'd7, 2'b00, 2'b11, 5'h1E, 16'hFFFE});
      vecs.push_back('{"add_r5",     16'hA6B2, K_ALU,  5, 3'd6, 3'd2, 3'd5, 2'b00, 2'b10, 5'h12, 16'hFFB2});
      vecs.push_back('{"mvn_r7_r5",  16'hB8E5, K_MVN,  4, 3'd0, 3'd5, 3'd7, 2'b11, 2'b00, 5'h05, 16'hFFE5});
      vecs.push_back('{"cmp_r3_r4",  16'hAB04, K_CMP,  4, 3'd3, 3'd4, 3'd0, 2'b01, 2'b00, 5'h04, 16'h0004});
      vecs.push_back('{"movi_r7_m128", 16'hD780, K_MOVI, 2, 3'd0, 3'd0, 3'd7, 2'b00, 2'b00, 5'h00, 16'hFF80});
      vecs.push_back('{"ill_e000",   16'hE000, K_ILL,  1, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 5'h00, 16'h0000});
      vecs.push_back('{"ill_c800",   16'hC800, K_ILL,  1, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 5'h00, 16'h0000});
      vecs.push_back('{"ill_ff80",   16'hFF80, K_ILL,  1, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 5'h00, 16'hFF80});
      vecs.push_back('{"and_r3",     16'hB579, K_ALU,  5, 3'd5, 3'd1, 3'd3, 2'b10, 2'b11, 5'h19, 16'h0079});

      // Reset state, checked while rst_n is still low
      #12;
      check("reset_low", {5'b0, act}, {5'b0, idle0});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_idle", {5'b0, act}, {5'b0, idle0});

      foreach (vecs[i]) run_vec(vecs[i], 1'b0, 16'h0000);

      // valid held high through a busy AND with the next word: no re-latch,
      // and the held MOV is accepted in the IDLE cycle right after done.
      run_vec(vecs[13], 1'b1, vecs[0].instr);
      run_vec(vecs[0], 1'b0, 16'h0000);

      // Reset asserted in EXEC of an ADD: immediate IDLE, no write, no done
      add_v       = vecs[2];
      instr_valid = 1'b1;
      instr       = add_v.instr;
      @(negedge clk);
      instr_valid = 1'b0;
      for (int k = 2; k <= 4; k++) @(negedge clk);
      check("rst_pre_exec", {5'b0, act}, {5'b0, exp_at(add_v, 4)});
      #2 rst_n = 1'b0;
      #1 check("rst_async", {5'b0, act}, {5'b0, idle0});
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("rst_hold%0d", k), {5'b0, act}, {5'b0, idle0});
      end
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check($sformatf("rst_after%0d", k), {5'b0, act}, {5'b0, idle0});
      end
      run_vec(vecs[1], 1'b0, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
